wr_bus_arbiter: RTL and testbench

- Shares the single system write bus between two write masters: master 0 (cpu core) and master 1 (boot loader / debug injector).
- Decodes each granted write to either the RAM write port or the UART transmit port (UART at 0x1000_0000).
- Sequences the UART busy/valid handshake, with a timeout so a stuck UART cannot hang the bus.
- Returns a one-cycle ack, plus an error flag on timeout, to the requesting master.

---
 rtl/wr_bus_arbiter_if.sv | 51 +++++
 rtl/wr_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wr_bus_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wr_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// wr_bus_arbiter_if
// Bundles the two write-master request channels, the RAM write port and the
// UART transmit port that surround wr_bus_arbiter.
//   m0_*/m1_*     : master request (req/addr/data) and completion (ack)
//   err           : timeout flag qualified by either ack
//   ram_wr_*      : RAM write strobe plus latched address/data
//   uart_*        : UART busy input, byte strobe and byte
//   bus_busy      : arbiter is not idle
// Modports:
//   slave  : the arbiter side
//   master : the side that drives requests and models the UART/RAM
// -----------------------------------------------------------------------------
interface wr_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_data;
    logic        m0_ack;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_data;
    logic        m1_ack;
    logic        err;
    logic        ram_wr_valid;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        uart_busy;
    logic        uart_wr_valid;
    logic [7:0]  uart_wr_data;
    logic        bus_busy;

    modport slave (
        input  m0_req, m0_addr, m0_data,
        input  m1_req, m1_addr, m1_data,
        input  uart_busy,
        output m0_ack, m1_ack, err,
        output ram_wr_valid, ram_wr_addr, ram_wr_data,
        output uart_wr_valid, uart_wr_data,
        output bus_busy
    );

    modport master (
        output m0_req, m0_addr, m0_data,
        output m1_req, m1_addr, m1_data,
        output uart_busy,
        input  m0_ack, m1_ack, err,
        input  ram_wr_valid, ram_wr_addr, ram_wr_data,
        input  uart_wr_valid, uart_wr_data,
        input  bus_busy
    );
endinterface

// File: rtl/wr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wr_bus_arbiter
// Shares one system write bus between master 0 (cpu) and master 1 (boot
// loader / debug). Each granted write is decoded to the RAM port or, when the
// address falls in the UART region, to the UART transmit port. UART busy is
// waited on with a bounded counter so a stuck UART cannot hang the bus.
// Ports:
//   clk        : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : wr_bus_arbiter_if.slave (masters, RAM port, UART port)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | arbitrate; latch winner's addr/data on a grant
// RAM_WR    | ram_wr_valid high for this cycle
// UART_WAIT | waiting for uart_busy low, counting busy cycles
// UART_WR   | uart_wr_valid high for this cycle
// DONE      | ack (and err) to the granted master; no arbitration
//
// All outputs are registered; they are set on the transition into the state
// that owns them, so each is high exactly while the FSM sits in that state.
// -----------------------------------------------------------------------------
module wr_bus_arbiter #(
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter logic [31:0] UART_MASK = 32'hF000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             i_reset_n,
    wr_bus_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_WR,
        UART_WAIT,
        UART_WR,
        DONE
    } state_t;

    localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [7:0]  r_cnt;
    logic        r_last_grant;
    logic        r_grant;        // 0 = master 0, 1 = master 1
    logic        r_err_lat;

    logic        r_m0_ack;
    logic        r_m1_ack;
    logic        r_err;
    logic        r_ram_wr_valid;
    logic        r_uart_wr_valid;
    logic        r_bus_busy;

    logic        w_any_req;
    logic        w_pick_m1;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_is_uart;

    // On a tie the master that did not win last time is chosen.
    assign w_any_req  = bus.m0_req | bus.m1_req;
    assign w_pick_m1  = bus.m1_req & (~bus.m0_req | ~r_last_grant);
    assign w_sel_addr = w_pick_m1 ? bus.m1_addr : bus.m0_addr;
    assign w_sel_data = w_pick_m1 ? bus.m1_data : bus.m0_data;
    assign w_is_uart  = ((w_sel_addr & UART_MASK) == UART_BASE);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_data          <= '0;
            r_cnt           <= '0;
            r_last_grant    <= 1'b1;
            r_grant         <= 1'b0;
            r_err_lat       <= 1'b0;
            r_m0_ack        <= 1'b0;
            r_m1_ack        <= 1'b0;
            r_err           <= 1'b0;
            r_ram_wr_valid  <= 1'b0;
            r_uart_wr_valid <= 1'b0;
            r_bus_busy      <= 1'b0;
        end else begin
            r_m0_ack        <= 1'b0;
            r_m1_ack        <= 1'b0;
            r_err           <= 1'b0;
            r_ram_wr_valid  <= 1'b0;
            r_uart_wr_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_addr       <= w_sel_addr;
                        r_data       <= w_sel_data;
                        r_grant      <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        r_cnt        <= '0;
                        r_bus_busy   <= 1'b1;
                        if (w_is_uart) begin
                            r_state <= UART_WAIT;
                        end else begin
                            r_state        <= RAM_WR;
                            r_ram_wr_valid <= 1'b1;
                        end
                    end
                end

                RAM_WR: begin
                    r_state  <= DONE;
                    r_m0_ack <= ~r_grant;
                    r_m1_ack <= r_grant;
                    r_err    <= r_err_lat;
                end

                UART_WAIT: begin
                    if (!bus.uart_busy) begin
                        r_state         <= UART_WR;
                        r_uart_wr_valid <= 1'b1;
                    end else if (r_cnt == L_CNT_LAST) begin
                        // Give up: the write is dropped and flagged.
                        r_err_lat <= 1'b1;
                        r_state   <= DONE;
                        r_m0_ack  <= ~r_grant;
                        r_m1_ack  <= r_grant;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                UART_WR: begin
                    r_state  <= DONE;
                    r_m0_ack <= ~r_grant;
                    r_m1_ack <= r_grant;
                    r_err    <= r_err_lat;
                end

                DONE: begin
                    // No arbitration here so a master dropping req on the
                    // ack edge is not granted again.
                    r_state    <= IDLE;
                    r_err_lat  <= 1'b0;
                    r_bus_busy <= 1'b0;
                end

                default: begin
                    r_state    <= IDLE;
                    r_err_lat  <= 1'b0;
                    r_bus_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m0_ack        = r_m0_ack;
    assign bus.m1_ack        = r_m1_ack;
    assign bus.err           = r_err;
    assign bus.ram_wr_valid  = r_ram_wr_valid;
    assign bus.ram_wr_addr   = r_addr;
    assign bus.ram_wr_data   = r_data;
    assign bus.uart_wr_valid = r_uart_wr_valid;
    assign bus.uart_wr_data  = r_data[7:0];
    assign bus.bus_busy      = r_bus_busy;

endmodule

// File: tb/tb_wr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wr_bus_arbiter
// Directed bench for wr_bus_arbiter. dut uses the default TIMEOUT; dut_to
// uses TIMEOUT = 4 for the timeout case. Inputs change 1 ns after a rising
// edge and outputs are checked at that same point, so each check sees the
// registered values produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_wr_bus_arbiter;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    // strobe/ack tallies observed on the falling edge
    int c0_ram, c0_uart, c0_ack0, c0_ack1;
    int c1_ram, c1_uart, c1_ack0, c1_ack1;
    int c0_both;

    int s_ack0, s_ack1, s_ram, s_uart;

    wr_bus_arbiter_if bus0 ();
    wr_bus_arbiter_if bus1 ();

    wr_bus_arbiter dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus0)
    );

    wr_bus_arbiter #(.TIMEOUT(4)) dut_to (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        c0_ram  += int'(bus0.ram_wr_valid);
        c0_uart += int'(bus0.uart_wr_valid);
        c0_ack0 += int'(bus0.m0_ack);
        c0_ack1 += int'(bus0.m1_ack);
        c0_both += int'((bus0.ram_wr_valid & bus0.uart_wr_valid) | (bus0.m0_ack & bus0.m1_ack));
        c1_ram  += int'(bus1.ram_wr_valid);
        c1_uart += int'(bus1.uart_wr_valid);
        c1_ack0 += int'(bus1.m0_ack);
        c1_ack1 += int'(bus1.m1_ack);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        c0_ram = 0; c0_uart = 0; c0_ack0 = 0; c0_ack1 = 0; c0_both = 0;
        c1_ram = 0; c1_uart = 0; c1_ack0 = 0; c1_ack1 = 0;

        rst_n = 1'b0;
        bus0.m0_req = 0; bus0.m0_addr = '0; bus0.m0_data = '0;
        bus0.m1_req = 0; bus0.m1_addr = '0; bus0.m1_data = '0;
        bus0.uart_busy = 0;
        bus1.m0_req = 0; bus1.m0_addr = '0; bus1.m0_data = '0;
        bus1.m1_req = 0; bus1.m1_addr = '0; bus1.m1_data = '0;
        bus1.uart_busy = 0;

        // ---------------- reset state
        step(); step();
        chk("rst_bus_busy", 32'(bus0.bus_busy), 0);
        chk("rst_ram_addr", bus0.ram_wr_addr, 0);
        chk("rst_acks_err", {29'd0, bus0.m0_ack, bus0.m1_ack, bus0.err}, 0);
        rst_n = 1'b1;
        step();

        // ---------------- single RAM write from m0
        bus0.m0_req = 1; bus0.m0_addr = 32'h0000_0040; bus0.m0_data = 32'hDEAD_BEEF;
        step();
        chk("ram_valid", 32'(bus0.ram_wr_valid), 1);
        chk("ram_addr", bus0.ram_wr_addr, 32'h0000_0040);
        chk("ram_data", bus0.ram_wr_data, 32'hDEAD_BEEF);
        chk("ram_early_ack", 32'(bus0.m0_ack), 0);
        step();
        chk("ram_ack", {30'd0, bus0.m0_ack, bus0.m1_ack}, 32'b10);
        chk("ram_err", 32'(bus0.err), 0);
        chk("ram_valid_off", 32'(bus0.ram_wr_valid), 0);
        bus0.m0_req = 0;
        step();
        step();
        chk("ram_idle", 32'(bus0.bus_busy), 0);
        chk("ram_no_uart", 32'(c0_uart), 0);
        chk("ram_ack_cnt", 32'(c0_ack0), 1);

        // ---------------- UART write from m1, UART idle
        s_ram = c0_ram;
        bus0.m1_req = 1; bus0.m1_addr = 32'h1000_0000; bus0.m1_data = 32'h0000_0141;
        step();
        chk("u_busy_n1", 32'(bus0.bus_busy), 1);
        chk("u_valid_n1", 32'(bus0.uart_wr_valid), 0);
        step();
        chk("u_valid_n2", 32'(bus0.uart_wr_valid), 1);
        chk("u_data", 32'(bus0.uart_wr_data), 32'h41);
        step();
        chk("u_ack", {30'd0, bus0.m0_ack, bus0.m1_ack}, 32'b01);
        chk("u_err", 32'(bus0.err), 0);
        bus0.m1_req = 0;
        step();
        step();
        chk("u_no_ram", 32'(c0_ram - s_ram), 0);

        // ---------------- simultaneous requests, alternating grants
        s_ack0 = c0_ack0; s_ack1 = c0_ack1;
        bus0.m0_req = 1; bus0.m0_addr = 32'h0000_0100; bus0.m0_data = 32'h0000_AAAA;
        bus0.m1_req = 1; bus0.m1_addr = 32'h0000_0200; bus0.m1_data = 32'h0000_BBBB;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tie_addr%0d", i), bus0.ram_wr_addr,
                (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            step();
            chk($sformatf("tie_ack%0d", i), {30'd0, bus0.m0_ack, bus0.m1_ack},
                (i % 2 == 0) ? 32'b10 : 32'b01);
            step();
        end
        bus0.m0_req = 0; bus0.m1_req = 0;
        step(); step();
        chk("tie_ack0_cnt", 32'(c0_ack0 - s_ack0), 2);
        chk("tie_ack1_cnt", 32'(c0_ack1 - s_ack1), 2);

        // ---------------- UART back-pressure, busy 10 cycles after grant
        s_uart = c0_uart;
        bus0.uart_busy = 1;
        bus0.m0_req = 1; bus0.m0_addr = 32'h1000_0004; bus0.m0_data = 32'h1234_5655;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("bp_no_valid", 32'(c0_uart - s_uart), 0);
        chk("bp_busy", 32'(bus0.bus_busy), 1);
        bus0.uart_busy = 0;
        step();
        chk("bp_valid", 32'(bus0.uart_wr_valid), 1);
        chk("bp_data", 32'(bus0.uart_wr_data), 32'h55);
        step();
        chk("bp_ack", {30'd0, bus0.m0_ack, bus0.m1_ack}, 32'b10);
        chk("bp_err", 32'(bus0.err), 0);
        bus0.m0_req = 0;
        step(); step();

        // ---------------- timeout on dut_to (TIMEOUT = 4)
        bus1.uart_busy = 1;
        bus1.m0_req = 1; bus1.m0_addr = 32'h1000_0008; bus1.m0_data = 32'h0000_0077;
        step();
        step(); step(); step();
        chk("to_no_ack_early", 32'(bus1.m0_ack), 0);
        step();
        chk("to_ack", 32'(bus1.m0_ack), 1);
        chk("to_err", 32'(bus1.err), 1);
        bus1.m0_req = 0;
        step();
        chk("to_err_clr", 32'(bus1.err), 0);
        step();
        chk("to_no_uart", 32'(c1_uart), 0);
        chk("to_idle", 32'(bus1.bus_busy), 0);
        bus1.m1_req = 1; bus1.m1_addr = 32'h0000_0044; bus1.m1_data = 32'h0000_0099;
        step();
        chk("to_next_ram", bus1.ram_wr_addr, 32'h0000_0044);
        chk("to_next_valid", 32'(bus1.ram_wr_valid), 1);
        step();
        chk("to_next_ack", {29'd0, bus1.m0_ack, bus1.m1_ack, bus1.err}, 32'b010);
        bus1.m1_req = 0;
        step(); step();

        // ---------------- async reset during UART_WAIT
        s_ack1 = c0_ack1;
        bus0.uart_busy = 1;
        bus0.m1_req = 1; bus0.m1_addr = 32'h1000_0000; bus0.m1_data = 32'h0000_0033;
        step();
        step();
        chk("ar_busy_before", 32'(bus0.bus_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy_now", 32'(bus0.bus_busy), 0);
        chk("ar_addr_now", bus0.ram_wr_addr, 0);
        bus0.m1_req = 0; bus0.uart_busy = 0;
        step(); step();
        bus0.m0_req = 1; bus0.m0_addr = 32'h0000_0300; bus0.m0_data = 32'h1;
        bus0.m1_req = 1; bus0.m1_addr = 32'h0000_0400; bus0.m1_data = 32'h2;
        rst_n = 1'b1;
        step();
        chk("ar_tie_addr", bus0.ram_wr_addr, 32'h0000_0300);
        step();
        chk("ar_tie_ack", {30'd0, bus0.m0_ack, bus0.m1_ack}, 32'b10);
        bus0.m0_req = 0; bus0.m1_req = 0;
        step(); step();
        chk("ar_no_m1_ack", 32'(c0_ack1 - s_ack1), 0);
        chk("excl_strobes", 32'(c0_both), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
